// File: rtl/conclover_mem_port.sv
// rtl/conclover_mem_port.sv - element-granular Avalon-MM master with one-word read cache
// and write-combining buffer.
module conclover_mem_port #(
   parameter int ADDR_W = 16,
   parameter int BUS_W  = 32,
   parameter int ELEM_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 avm_m1_read,
   output logic                 avm_m1_write,
   output logic [ADDR_W-1:0]    avm_m1_address,
   output logic [BUS_W/8-1:0]   avm_m1_byteenable,
   output logic [BUS_W-1:0]     avm_m1_writedata,
   input  logic [BUS_W-1:0]     avm_m1_readdata,
   input  logic                 avm_m1_waitrequest,
   input  logic                 avm_m1_readdatavalid,
   input  logic [ADDR_W-1:0]    read_offset,
   input  logic [ADDR_W-1:0]    write_offset,
   input  logic [ADDR_W-1:0]    stop_write_offset,
   input  logic [ADDR_W-1:0]    rel_addr,
   input  logic                 read,
   input  logic                 write,
   input  logic                 flush,
   input  logic [ELEM_W-1:0]    save_data,
   output logic [ELEM_W-1:0]    read_data,
   output logic                 rdy,
   output logic                 busy
);
   localparam int BE = BUS_W / 8;
   localparam int EB = ELEM_W / 8;
   localparam int BL = $clog2(BE);
   localparam int EL = $clog2(EB);
   localparam int NL = BE / EB;
   localparam int LW = (NL > 1) ? $clog2(NL) : 1;
   localparam int TW = ADDR_W - BL;
   localparam logic [ADDR_W-1:0] EL_MASK = ADDR_W'((1 << EL) - 1);
   localparam logic [BE-1:0]     ELEM_BE = BE'((1 << EB) - 1);

   typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_FLUSH, S_WR_MERGE, S_DONE} state_t;
   typedef enum logic [1:0] {OP_RD, OP_WR, OP_FL} op_t;

   function automatic logic [LW-1:0] lane_of(input logic [ADDR_W-1:0] a);
      return LW'((a >> EL) & ADDR_W'(NL - 1));
   endfunction

   state_t            state, next;
   op_t               op;
   logic              merged, stop_hit;
   logic [ADDR_W-1:0] req_addr;
   logic [ELEM_W-1:0] req_data;
   logic [BUS_W-1:0]  rc_data, wb_data;
   logic [TW-1:0]     rc_tag, wb_tag;
   logic              rc_valid;
   logic [BE-1:0]     wb_mask;

   logic [ADDR_W-1:0] raddr, waddr;
   logic [TW-1:0]     rtag, wtag, req_tag;
   logic [LW-1:0]     req_lane;
   logic [BE-1:0]     new_mask;
   logic              dirty, accept;

   assign raddr    = (rel_addr + read_offset) & ~EL_MASK;
   assign waddr    = (rel_addr + write_offset) & ~EL_MASK;
   assign rtag     = raddr[ADDR_W-1:BL];
   assign wtag     = waddr[ADDR_W-1:BL];
   assign req_tag  = req_addr[ADDR_W-1:BL];
   assign req_lane = lane_of(req_addr);
   assign new_mask = wb_mask | (ELEM_BE << (req_lane * EB));
   assign dirty    = |wb_mask;
   assign accept   = (state == S_IDLE) && (flush || write || read);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         S_IDLE: begin
            if (flush)
               next = dirty ? S_WR_FLUSH : S_DONE;
            else if (write)
               next = (dirty && wb_tag != wtag) ? S_WR_FLUSH : S_WR_MERGE;
            else if (read) begin
               if (dirty && wb_tag == rtag)          next = S_WR_FLUSH;
               else if (rc_valid && rc_tag == rtag)  next = S_DONE;
               else                                  next = S_RD_REQ;
            end
         end
         S_RD_REQ:   if (!avm_m1_waitrequest) next = S_RD_WAIT;
         S_RD_WAIT:  if (avm_m1_readdatavalid) next = S_DONE;
         S_WR_FLUSH: begin
            if (!avm_m1_waitrequest) begin
               if (op == OP_RD)                 next = S_RD_REQ;
               else if (op == OP_WR && !merged) next = S_WR_MERGE;
               else                             next = S_DONE;
            end
         end
         S_WR_MERGE: next = (&new_mask || stop_hit) ? S_WR_FLUSH : S_DONE;
         S_DONE:     next = S_IDLE;
         default:    next = S_IDLE;
      endcase
   end

   // Bus outputs decode straight from the state register, so an async reset drops them at once.
   always_comb begin
      avm_m1_read       = 1'b0;
      avm_m1_write      = 1'b0;
      avm_m1_address    = '0;
      avm_m1_byteenable = '0;
      avm_m1_writedata  = '0;
      read_data         = '0;
      rdy               = 1'b0;
      busy              = (state != S_IDLE);
      case (state)
         S_RD_REQ: begin
            avm_m1_read       = 1'b1;
            avm_m1_address    = {req_tag, {BL{1'b0}}};
            avm_m1_byteenable = '1;
         end
         S_WR_FLUSH: begin
            avm_m1_write      = 1'b1;
            avm_m1_address    = {wb_tag, {BL{1'b0}}};
            avm_m1_byteenable = wb_mask;
            avm_m1_writedata  = wb_data;
         end
         S_DONE: begin
            rdy = 1'b1;
            if (op == OP_RD) read_data = rc_data[req_lane * ELEM_W +: ELEM_W];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op       <= OP_RD;
         merged   <= 1'b0;
         stop_hit <= 1'b0;
         req_addr <= '0;
         req_data <= '0;
         rc_data  <= '0;
         rc_tag   <= '0;
         rc_valid <= 1'b0;
         wb_data  <= '0;
         wb_tag   <= '0;
         wb_mask  <= '0;
      end else begin
         if (accept) begin
            op       <= flush ? OP_FL : (write ? OP_WR : OP_RD);
            req_addr <= write ? waddr : raddr;
            req_data <= save_data;
            stop_hit <= (waddr == stop_write_offset);
            merged   <= 1'b0;
            if (flush) rc_valid <= 1'b0;
         end
         if (state == S_RD_WAIT && avm_m1_readdatavalid) begin
            rc_data  <= avm_m1_readdata;
            rc_tag   <= req_tag;
            rc_valid <= 1'b1;
         end
         // Flushed bytes are zeroed so a later partial flush never carries stale lanes.
         if (state == S_WR_FLUSH && !avm_m1_waitrequest) begin
            wb_mask <= '0;
            wb_data <= '0;
         end
         if (state == S_WR_MERGE) begin
            wb_data[req_lane * ELEM_W +: ELEM_W] <= req_data;
            wb_mask <= new_mask;
            wb_tag  <= req_tag;
            merged  <= 1'b1;
            if (rc_valid && rc_tag == req_tag)
               rc_data[req_lane * ELEM_W +: ELEM_W] <= req_data;
         end
      end
   end
endmodule
